// File: rtl/mux_n_1_scan.sv
// N:1, W-bit multiplexer with a registered output stage and a tri-state output.
// In direct mode the channel comes from Select_In. In scan mode an internal
// sequencer steps through every channel in turn. Each channel is held for
// Dwell_In+1 cycles, and Wrap_Out pulses when the sweep returns to channel 0.
module mux_n_1_scan #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 8,
  parameter int SEL_WIDTH   = 3,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                           Clock_In,
  input  logic                           Reset_In,
  input  logic                           Enable_In,
  input  logic                           Mode_In,
  input  logic [SEL_WIDTH-1:0]           Select_In,
  input  logic [DWELL_WIDTH-1:0]         Dwell_In,
  input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
  output logic [DATA_WIDTH-1:0]          MUX_Data_Out,
  output logic [SEL_WIDTH-1:0]           Channel_Out,
  output logic                           Valid_Out,
  output logic                           Wrap_Out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CHANNELS - 1);

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [SEL_WIDTH-1:0]     chan_q, chan_d;
  logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
  logic                     valid_q, valid_d;
  logic                     wrap_q, wrap_d;

  logic                     scan_first;
  logic                     advance;
  logic                     sel_in_range;
  logic [SEL_WIDTH-1:0]     next_chan;
  logic [SEL_WIDTH-1:0]     read_idx;
  logic [DATA_WIDTH-1:0]    read_data;

  // Mode decode: the state is re-evaluated on every edge from enable and mode.
  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = IDLE;
    if (Enable_In) state_d = Mode_In ? SCAN : DIRECT;
  end

  // Sequencer helpers. Scan position is dropped whenever the block leaves SCAN,
  // so any entry into SCAN restarts at channel 0.
  assign scan_first   = (state_q != SCAN);
  assign advance      = (dwell_q >= Dwell_In);
  assign next_chan    = (chan_q == LAST_CH) ? '0 : chan_q + SEL_WIDTH'(1);
  assign sel_in_range = (int'(Select_In) < CHANNELS);

  // Choose which channel is read into the data register on this edge.
  always_comb begin
    read_idx = chan_q;
    if (state_d == DIRECT)  read_idx = Select_In;
    else if (scan_first)    read_idx = '0;
    else if (advance)       read_idx = next_chan;
  end

  // Channel read mux. It is bounds-checked, so an out-of-range index returns 0 when CHANNELS is not a power of 2.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (read_idx == SEL_WIDTH'(i)) read_data = Data_In[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state values for the datapath and status registers.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    dwell_d = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_d)
      DIRECT: begin
        chan_d = Select_In;
        if (sel_in_range) begin
          data_d  = read_data;
          valid_d = 1'b1;
        end else begin
          data_d  = '0;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        data_d  = read_data;
        if (scan_first) begin
          chan_d = '0;
        end else if (advance) begin
          chan_d = next_chan;
          wrap_d = (next_chan == '0);
        end else begin
          chan_d  = chan_q;
          dwell_d = dwell_q + DWELL_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // State and output registers, with synchronous reset taking priority over everything else.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      data_q  <= '0;
      chan_q  <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign MUX_Data_Out = Enable_In ? data_q : {DATA_WIDTH{1'bz}};
  assign Channel_Out  = chan_q;
  assign Valid_Out    = valid_q;
  assign Wrap_Out     = wrap_q;

endmodule
